// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and index-width helper for the scoreboarded register file
package regfile_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_NUM_REGS = 4;
  function automatic int addr_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits with reserve-at-issue / clear-at-writeback
// Ports: clk, reset (async, active-high); write_enable/reg_write clear a busy bit;
// rsv_enable/rsv_reg request a reservation; rsv_ok/stall report acceptance; busy_vec is the state.
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter bit ZERO_REG = 1'b0,
  localparam int ADDR_W = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_enable,
  input  logic [ADDR_W-1:0]   reg_write,
  input  logic                rsv_enable,
  input  logic [ADDR_W-1:0]   rsv_reg,
  output logic                rsv_ok,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NUM_REGS);
  logic [NUM_REGS-1:0] busy, busy_nxt;
  logic rsv_valid, rsv_zero;
  assign rsv_valid = {1'b0, rsv_reg} < LIM;
  assign rsv_zero = ZERO_REG && rsv_reg == '0;
  // a busy register may be re-reserved only when its current producer retires this cycle
  assign rsv_ok = rsv_enable && rsv_valid &&
                  (rsv_zero || !busy[rsv_reg] || (write_enable && reg_write == rsv_reg));
  assign stall = rsv_enable && !rsv_ok;
  assign busy_vec = busy;
  // set has priority over clear: the new producer is still pending
  always_comb begin
    busy_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++)
      busy_nxt[i] = (rsv_ok && !rsv_zero && rsv_reg == ADDR_W'(i)) ||
                    (busy[i] && !(write_enable && reg_write == ADDR_W'(i)));
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) busy <= '0;
    else busy <= busy_nxt;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: N x W register file, two combinational reads, one write, bypass and busy scoreboard
// Ports: clk, reset (async, active-high); write_enable/reg_write/write_data writeback port;
// src1/src2 read indices with srcN_data/srcN_busy; rsv_enable/rsv_reg issue reservation,
// rsv_ok/stall acceptance; busy_vec registered busy bits.
module regfile_sb import regfile_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS = 1'b1,
  localparam int ADDR_W = addr_w(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                write_enable,
  input  logic [ADDR_W-1:0]   reg_write,
  input  logic [DATA_W-1:0]   write_data,
  input  logic [ADDR_W-1:0]   src1,
  input  logic [ADDR_W-1:0]   src2,
  output logic [DATA_W-1:0]   src1_data,
  output logic [DATA_W-1:0]   src2_data,
  output logic                src1_busy,
  output logic                src2_busy,
  input  logic                rsv_enable,
  input  logic [ADDR_W-1:0]   rsv_reg,
  output logic                rsv_ok,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(NUM_REGS);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic wr_ok;
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LIM;
  endfunction
  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && a == '0;
  endfunction
  // forwarding only applies to real, writable registers
  function automatic logic byp(input logic [ADDR_W-1:0] a);
    return BYPASS && write_enable && reg_write == a && in_range(a) && !is_zero(a);
  endfunction
  assign wr_ok = write_enable && in_range(reg_write) && !is_zero(reg_write);
  always_comb begin
    src1_data = !in_range(src1) || is_zero(src1) ? '0 : byp(src1) ? write_data : regs[src1];
    src2_data = !in_range(src2) || is_zero(src2) ? '0 : byp(src2) ? write_data : regs[src2];
    src1_busy = in_range(src1) && !byp(src1) && busy_vec[src1];
    src2_busy = in_range(src2) && !byp(src2) && busy_vec[src2];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    else if (wr_ok) regs[reg_write] <= write_data;
  regfile_scoreboard #(.NUM_REGS(NUM_REGS), .ZERO_REG(ZERO_REG)) u_sb (
    .clk(clk),
    .reset(reset),
    .write_enable(write_enable),
    .reg_write(reg_write),
    .rsv_enable(rsv_enable),
    .rsv_reg(rsv_reg),
    .rsv_ok(rsv_ok),
    .stall(stall),
    .busy_vec(busy_vec)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed table-driven bench for regfile_sb in four configurations
module tb_regfile_sb;
  logic clk = 1'b0, reset = 1'b1, run = 1'b1;
  always #5 if (run) clk = ~clk;
  logic we, re;
  logic [1:0] wreg, s1, s2, rreg;
  logic [7:0] wd;
  logic [7:0] a_d1, a_d2, b_d1, b_d2, c_d1, c_d2;
  logic a_b1, a_b2, a_ok, a_st, b_b1, b_b2, b_ok, b_st, c_b1, c_b2, c_ok, c_st;
  logic [3:0] a_bv, b_bv, c_bv;
  logic dwe, dre;
  logic [2:0] dwreg, ds1, ds2, drreg;
  logic [15:0] dwd, d_d1, d_d2;
  logic d_b1, d_b2, d_ok, d_st;
  logic [5:0] d_bv;
  int n_cmp = 0, n_bad = 0;
  regfile_sb u_a (.clk(clk), .reset(reset), .write_enable(we), .reg_write(wreg), .write_data(wd),
    .src1(s1), .src2(s2), .src1_data(a_d1), .src2_data(a_d2), .src1_busy(a_b1), .src2_busy(a_b2),
    .rsv_enable(re), .rsv_reg(rreg), .rsv_ok(a_ok), .stall(a_st), .busy_vec(a_bv));
  regfile_sb #(.BYPASS(1'b0)) u_b (.clk(clk), .reset(reset), .write_enable(we), .reg_write(wreg),
    .write_data(wd), .src1(s1), .src2(s2), .src1_data(b_d1), .src2_data(b_d2), .src1_busy(b_b1),
    .src2_busy(b_b2), .rsv_enable(re), .rsv_reg(rreg), .rsv_ok(b_ok), .stall(b_st), .busy_vec(b_bv));
  regfile_sb #(.ZERO_REG(1'b1)) u_c (.clk(clk), .reset(reset), .write_enable(we), .reg_write(wreg),
    .write_data(wd), .src1(s1), .src2(s2), .src1_data(c_d1), .src2_data(c_d2), .src1_busy(c_b1),
    .src2_busy(c_b2), .rsv_enable(re), .rsv_reg(rreg), .rsv_ok(c_ok), .stall(c_st), .busy_vec(c_bv));
  regfile_sb #(.DATA_W(16), .NUM_REGS(6)) u_d (.clk(clk), .reset(reset), .write_enable(dwe),
    .reg_write(dwreg), .write_data(dwd), .src1(ds1), .src2(ds2), .src1_data(d_d1), .src2_data(d_d2),
    .src1_busy(d_b1), .src2_busy(d_b2), .rsv_enable(dre), .rsv_reg(drreg), .rsv_ok(d_ok),
    .stall(d_st), .busy_vec(d_bv));
  typedef struct {
    logic we; logic [1:0] wreg; logic [7:0] wd; logic [1:0] s1, s2; logic re; logic [1:0] rreg;
    logic [7:0] d1, d2; logic b1, b2, ok, st; logic [3:0] bv;
  } vec_t;
  vec_t tbl [10];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic idle();
    we = 0; re = 0; wreg = 0; wd = 0; s1 = 0; s2 = 0; rreg = 0;
    dwe = 0; dre = 0; dwreg = 0; dwd = 0; ds1 = 0; ds2 = 0; drreg = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    tbl[0] = '{1'b1, 2'd3, 8'h5C, 2'd0, 2'd3, 1'b0, 2'd0, 8'h00, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000};
    tbl[1] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd3, 1'b1, 2'd1, 8'h00, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[2] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 1'b1, 2'd1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0010};
    tbl[3] = '{1'b1, 2'd1, 8'h11, 2'd1, 2'd3, 1'b0, 2'd0, 8'h11, 8'h5C, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010};
    tbl[4] = '{1'b0, 2'd0, 8'h00, 2'd1, 2'd2, 1'b1, 2'd2, 8'h11, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000};
    tbl[5] = '{1'b1, 2'd2, 8'h77, 2'd2, 2'd1, 1'b1, 2'd2, 8'h77, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100};
    tbl[6] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd3, 1'b0, 2'd0, 8'h77, 8'h5C, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0100};
    tbl[7] = '{1'b1, 2'd0, 8'hFF, 2'd0, 2'd2, 1'b1, 2'd0, 8'hFF, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0100};
    tbl[8] = '{1'b1, 2'd3, 8'hA5, 2'd3, 2'd0, 1'b1, 2'd3, 8'hA5, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0101};
    tbl[9] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd0, 1'b1, 2'd0, 8'hA5, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 4'b1101};
    idle();
    repeat (2) @(negedge clk);
    chk("rst_a_data", 32'(a_d1), 32'h0);
    chk("rst_a_bv", 32'(a_bv), 32'h0);
    chk("rst_d_bv", 32'(d_bv), 32'h0);
    reset = 0;
    @(negedge clk);
    // async reset with the clock halted
    we = 1; wreg = 2; wd = 8'hAA; re = 1; rreg = 3;
    tick();
    idle(); s1 = 2;
    #1;
    chk("pre_rst_r2", 32'(a_d1), 32'hAA);
    chk("pre_rst_bv", 32'(a_bv), 32'b1000);
    run = 0;
    #7 reset = 1;
    #1;
    chk("async_rst_r2", 32'(a_d1), 32'h0);
    chk("async_rst_bv", 32'(a_bv), 32'h0);
    chk("async_rst_c_bv", 32'(c_bv), 32'h0);
    #2 reset = 0;
    #1 run = 1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      we = tbl[i].we; wreg = tbl[i].wreg; wd = tbl[i].wd; s1 = tbl[i].s1; s2 = tbl[i].s2;
      re = tbl[i].re; rreg = tbl[i].rreg;
      #1;
      chk($sformatf("v%0d_d1", i), 32'(a_d1), 32'(tbl[i].d1));
      chk($sformatf("v%0d_d2", i), 32'(a_d2), 32'(tbl[i].d2));
      chk($sformatf("v%0d_b1", i), 32'(a_b1), 32'(tbl[i].b1));
      chk($sformatf("v%0d_b2", i), 32'(a_b2), 32'(tbl[i].b2));
      chk($sformatf("v%0d_ok", i), 32'(a_ok), 32'(tbl[i].ok));
      chk($sformatf("v%0d_stall", i), 32'(a_st), 32'(tbl[i].st));
      chk($sformatf("v%0d_bv", i), 32'(a_bv), 32'(tbl[i].bv));
      tick();
    end
    idle();
    reset = 1;
    #1 reset = 0;
    // bypass on vs off
    we = 1; wreg = 3; wd = 8'h5C; s2 = 3;
    #1;
    chk("byp_a_d2", 32'(a_d2), 32'h5C);
    chk("nobyp_b_d2_old", 32'(b_d2), 32'h00);
    tick();
    idle(); s2 = 3;
    #1;
    chk("nobyp_b_d2_new", 32'(b_d2), 32'h5C);
    re = 1; rreg = 1;
    tick();
    idle(); we = 1; wreg = 1; wd = 8'h11; s1 = 1;
    #1;
    chk("nobyp_b_busy", 32'(b_b1), 32'h1);
    chk("nobyp_b_d1_old", 32'(b_d1), 32'h0);
    chk("byp_a_busy", 32'(a_b1), 32'h0);
    tick();
    idle(); s1 = 1;
    #1;
    chk("nobyp_b_d1_new", 32'(b_d1), 32'h11);
    chk("nobyp_b_bv", 32'(b_bv), 32'h0);
    // hard-wired zero register
    we = 1; wreg = 0; wd = 8'hFF; re = 1; rreg = 0; s1 = 0;
    #1;
    chk("zero_c_d1_byp", 32'(c_d1), 32'h0);
    chk("zero_c_ok", 32'(c_ok), 32'h1);
    chk("zero_c_stall", 32'(c_st), 32'h0);
    tick();
    idle();
    #1;
    chk("zero_c_d1", 32'(c_d1), 32'h0);
    chk("zero_c_bv", 32'(c_bv), 32'h0);
    chk("nozero_a_bv", 32'(a_bv), 32'b0001);
    chk("nozero_a_d1", 32'(a_d1), 32'hFF);
    // 6 x 16 with out-of-range indices
    dwe = 1; dwreg = 5; dwd = 16'hBEEF; dre = 1; drreg = 7; ds1 = 7; ds2 = 5;
    #1;
    chk("oor_rsv_ok", 32'(d_ok), 32'h0);
    chk("oor_stall", 32'(d_st), 32'h1);
    chk("oor_d1", 32'(d_d1), 32'h0);
    chk("oor_b1", 32'(d_b1), 32'h0);
    chk("d_byp_r5", 32'(d_d2), 32'hBEEF);
    tick();
    dwe = 1; dwreg = 6; dwd = 16'h1234; dre = 0; ds1 = 5; ds2 = 6;
    #1;
    chk("d_r5", 32'(d_d1), 32'hBEEF);
    chk("oor6_d2", 32'(d_d2), 32'h0);
    chk("oor6_b2", 32'(d_b2), 32'h0);
    tick();
    dwe = 0;
    for (int k = 0; k < 5; k++) begin
      ds1 = 3'(k);
      #1;
      chk($sformatf("d_r%0d_untouched", k), 32'(d_d1), 32'h0);
    end
    ds2 = 5; dre = 1; drreg = 6;
    #1;
    chk("d_r5_kept", 32'(d_d2), 32'hBEEF);
    chk("oor6_stall", 32'(d_st), 32'h1);
    drreg = 5;
    #1;
    chk("d_rsv5_ok", 32'(d_ok), 32'h1);
    tick();
    dre = 0;
    #1;
    chk("d_bv", 32'(d_bv), 32'b100000);
    chk("d_b2_busy", 32'(d_b2), 32'h1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
